// File: rtl/remote_input_conditioner.sv
// remote_input_conditioner
//   Front end for both player remotes. The raw active-low button lines are
//   synchronised, debounced and checked so that only a single, stable,
//   unlocked button press is reported downstream. Any other pattern is
//   rejected until every button has been released.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   rm_raw     in   WIDTH  raw remote lines, active-low, asynchronous to clk
//   lock       in   1      1 = presses are ignored
//   rm_bcd     out  WIDTH  clean code; all-ones when idle, else the accepted one-low pattern
//   rm_valid   out  1      one-cycle pulse when a press is accepted
//   err_multi  out  1      one-cycle pulse when a stable multi-button pattern is rejected
module remote_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rm_raw,
  input  logic             lock,
  output logic [WIDTH-1:0] rm_bcd,
  output logic             rm_valid,
  output logic             err_multi
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REJECT
  } state_t;

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] candidate_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [CNT_W-1:0] cnt_reg;
  state_t           state_reg;

  logic [WIDTH-1:0] pressed_bits;
  logic             any_low;
  logic             multi_low;
  logic             valid_code;

  // Synchroniser and debouncer. The counter restarts whenever the
  // synchronised pattern moves and saturates once the pattern has held
  // long enough; only then is it copied into the stable register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg        <= ALL_ONES;
      s2_reg        <= ALL_ONES;
      candidate_reg <= ALL_ONES;
      stable_reg    <= ALL_ONES;
      cnt_reg       <= '0;
    end else begin
      s1_reg <= rm_raw;
      s2_reg <= s1_reg;
      if (s2_reg != candidate_reg) begin
        candidate_reg <= s2_reg;
        cnt_reg       <= '0;
      end else if (cnt_reg < CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (stable_reg != candidate_reg) begin
        stable_reg <= candidate_reg;
      end
    end
  end

  // Buttons are active-low: invert, then x & (x-1) is non-zero exactly
  // when two or more bits are set.
  assign pressed_bits = ~stable_reg;
  assign any_low      = |pressed_bits;
  assign multi_low    = |(pressed_bits & (pressed_bits - ONE));
  assign valid_code   = any_low & ~multi_low;

  // Press qualification FSM with registered outputs; pulses default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rm_bcd    <= ALL_ONES;
      rm_valid  <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      rm_valid  <= 1'b0;
      err_multi <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (valid_code && !lock) begin
            rm_bcd    <= stable_reg;
            rm_valid  <= 1'b1;
            state_reg <= PRESSED;
          end else if (valid_code) begin
            state_reg <= REJECT;
          end else if (multi_low) begin
            // Reported regardless of lock.
            err_multi <= 1'b1;
            state_reg <= REJECT;
          end
        end
        PRESSED: begin
          if (stable_reg == rm_bcd) begin
            state_reg <= PRESSED;
          end else if (!any_low) begin
            rm_bcd    <= ALL_ONES;
            state_reg <= IDLE;
          end else begin
            // Second button or slide to another key: drop the code and
            // wait for a full release before accepting anything new.
            rm_bcd    <= ALL_ONES;
            err_multi <= multi_low;
            state_reg <= REJECT;
          end
        end
        REJECT: begin
          rm_bcd <= ALL_ONES;
          if (!any_low) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          rm_bcd    <= ALL_ONES;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
